// File: rtl/chip_link_host.sv
// chip_link_host
// Host-side link to the my_chip 12-bit pin interface. Accepts an operand pair
// and op select from the system side, streams them to the chip four bits at a
// time, waits for the chip's result flag and reassembles the two result bytes
// into one 16-bit response (or reports a timeout).
//
// Ports:
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_a, req_b operands, req_op 1=add 0=mul
//   rsp_valid/rsp_ready   response handshake; rsp_data {hi,lo}, rsp_err timeout flag
//   link_out[11:0]        to chip io_in: [3:0] A nibble, [7:4] B nibble, [8] op, [9] strobe
//   link_in[11:0]         from chip io_out: [7:0] result byte, [8] valid flag
module chip_link_host #(
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   input  logic        req_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic [11:0] link_out,
   input  logic [11:0] link_in
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_COMMIT,
      ST_WAIT,
      ST_CAP_HI,
      ST_RESP
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_next;
   logic [1:0]  nib_idx, nib_next;
   logic [7:0]  timer, timer_next;
   logic [15:0] a_reg, b_reg;
   logic        op_reg;
   logic [7:0]  lo_byte;
   logic [15:0] rsp_data_next;
   logic        rsp_err_next;
   logic [11:0] link_next;

   // On the accept cycle the operand registers are not loaded yet, so the
   // first nibble has to come straight from the request inputs.
   logic [15:0] a_src, b_src;
   logic        op_src;
   logic [3:0]  a_nib, b_nib;

   // Upper link_in bits carry nothing the host uses.
   logic        link_in_unused;

   assign link_in_unused = ^link_in[11:9];

   assign a_src  = (state == ST_IDLE) ? req_a  : a_reg;
   assign b_src  = (state == ST_IDLE) ? req_b  : b_reg;
   assign op_src = (state == ST_IDLE) ? req_op : op_reg;
   assign a_nib  = a_src[{nib_next, 2'b00} +: 4];
   assign b_nib  = b_src[{nib_next, 2'b00} +: 4];

   assign req_ready = (state == ST_IDLE) && !reset;
   assign rsp_valid = (state == ST_RESP);

   always_comb begin
      state_next    = state;
      nib_next      = nib_idx;
      timer_next    = timer;
      rsp_data_next = rsp_data;
      rsp_err_next  = rsp_err;

      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               state_next = ST_SEND;
               nib_next   = 2'd0;
            end
         end
         ST_SEND: begin
            if (nib_idx == 2'd3) begin
               state_next = ST_COMMIT;
            end else begin
               nib_next = nib_idx + 2'd1;
            end
         end
         ST_COMMIT: begin
            state_next = ST_WAIT;
            timer_next = 8'd0;
         end
         ST_WAIT: begin
            // A valid flag on the final counted cycle still wins over timeout.
            if (link_in[8]) begin
               state_next = ST_CAP_HI;
            end else if (timer == TIMEOUT_LAST) begin
               state_next    = ST_RESP;
               rsp_data_next = 16'h0000;
               rsp_err_next  = 1'b1;
            end else begin
               timer_next = timer + 8'd1;
            end
         end
         ST_CAP_HI: begin
            state_next    = ST_RESP;
            rsp_data_next = {link_in[7:0], lo_byte};
            rsp_err_next  = 1'b0;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // link_out is registered, so it is decoded from the state being entered.
      link_next = 12'h000;
      case (state_next)
         ST_SEND:   link_next = {2'b00, 1'b1, op_src, b_nib, a_nib};
         ST_COMMIT: link_next = {2'b00, 1'b1, op_src, 8'h00};
         ST_WAIT,
         ST_CAP_HI: link_next = {2'b00, 1'b0, op_src, 8'h00};
         default:   link_next = 12'h000;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         nib_idx  <= 2'd0;
         timer    <= 8'd0;
         a_reg    <= 16'h0000;
         b_reg    <= 16'h0000;
         op_reg   <= 1'b0;
         lo_byte  <= 8'h00;
         rsp_data <= 16'h0000;
         rsp_err  <= 1'b0;
         link_out <= 12'h000;
      end else begin
         state    <= state_next;
         nib_idx  <= nib_next;
         timer    <= timer_next;
         rsp_data <= rsp_data_next;
         rsp_err  <= rsp_err_next;
         link_out <= link_next;
         if (state == ST_IDLE && req_valid) begin
            a_reg  <= req_a;
            b_reg  <= req_b;
            op_reg <= req_op;
         end
         if (state == ST_WAIT && link_in[8]) begin
            lo_byte <= link_in[7:0];
         end
      end
   end

endmodule

// File: tb/tb_chip_link_host.sv
// tb_chip_link_host
// Directed bench for chip_link_host. A behavioural chip model watches link_out,
// rebuilds the operands from the strobed nibbles, and answers three WAIT
// cycles after the strobe burst with the lo byte (flag set) then the hi byte.
module tb_chip_link_host;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic [11:0] link_out;
   logic [11:0] link_in = '0;

   int compared   = 0;
   int mismatched = 0;

   // chip model state
   int          strobe_cnt = 0;
   int          last_burst = 0;
   int          bursts     = 0;
   int          wcnt       = 0;
   bit          waiting    = 0;
   bit          pending_hi = 0;
   bit          clear_next = 0;
   bit          chip_enable = 1;
   bit          op_high_seen = 0;
   logic [15:0] cap_a = '0;
   logic [15:0] cap_b = '0;
   logic        cap_op = 1'b0;
   logic [15:0] chip_res = '0;

   chip_link_host #(.TIMEOUT_CYCLES(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .link_out  (link_out),
      .link_in   (link_in)
   );

   always #5 clock = ~clock;

   // The chip model runs on the falling edge so its link_in changes sit
   // half a cycle away from the edge where the host samples them.
   always @(negedge clock) begin
      if (reset) begin
         strobe_cnt = 0;
         wcnt       = 0;
         waiting    = 0;
         pending_hi = 0;
         clear_next = 0;
         link_in    = '0;
      end else begin
         if (pending_hi) begin
            link_in    = {3'b101, 1'b0, chip_res[15:8]};
            pending_hi = 0;
            clear_next = 1;
         end else if (clear_next) begin
            link_in    = '0;
            clear_next = 0;
         end
         if (link_out[8]) op_high_seen = 1;
         if (link_out[9]) begin
            if (strobe_cnt == 0) waiting = 0;
            if (strobe_cnt < 4) begin
               cap_a[4*strobe_cnt +: 4] = link_out[3:0];
               cap_b[4*strobe_cnt +: 4] = link_out[7:4];
               cap_op = link_out[8];
            end
            strobe_cnt++;
         end else if (strobe_cnt != 0) begin
            last_burst = strobe_cnt;
            bursts++;
            strobe_cnt = 0;
            wcnt       = 1;
            waiting    = 1;
         end else if (waiting) begin
            wcnt++;
            if (wcnt == 3 && chip_enable) begin
               chip_res   = cap_op ? (cap_a + cap_b) : 16'(cap_a * cap_b);
               link_in    = {3'b101, 1'b1, chip_res[7:0]};
               pending_hi = 1;
               waiting    = 0;
            end
         end
      end
   end

   task automatic send_req(input logic [15:0] a, input logic [15:0] b, input logic op, output bit ok);
      req_a     = a;
      req_b     = b;
      req_op    = op;
      req_valid = 1'b1;
      ok        = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (req_ready) ok = 1;
         @(posedge clock); #1;
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat, output bit ok);
      lat = 0;
      ok  = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(posedge clock); #1;
         lat++;
         if (rsp_valid) ok = 1;
      end
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      compared++; if (req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
      compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      compared++; if (rsp_data !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
      compared++; if (rsp_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
      compared++; if (link_out !== 12'h000) begin mismatched++; $display("[TB] FAIL reset_link_out: got %h expected 000", link_out); end
      reset = 1'b0;
      #1;
      compared++; if (req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready); end
      @(posedge clock); #1;
      compared++; if (link_out !== 12'h000) begin mismatched++; $display("[TB] FAIL idle_link_out: got %h expected 000", link_out); end
   endtask

   task automatic test_add();
      bit ok;
      int lat;
      send_req(16'h1234, 16'h0011, 1'b1, ok);
      compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL add_accept: got %b expected 1", ok); end
      wait_rsp(lat, ok);
      compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL add_rsp_timeout: got %b expected 1", ok); end
      compared++; if (lat !== 9) begin mismatched++; $display("[TB] FAIL add_latency: got %0d expected 9", lat); end
      compared++; if (rsp_data !== 16'h1245) begin mismatched++; $display("[TB] FAIL add_data: got %h expected 1245", rsp_data); end
      compared++; if (rsp_err !== 1'b0) begin mismatched++; $display("[TB] FAIL add_err: got %b expected 0", rsp_err); end
      compared++; if (cap_a !== 16'h1234) begin mismatched++; $display("[TB] FAIL add_nibbles_a: got %h expected 1234", cap_a); end
      compared++; if (cap_b !== 16'h0011) begin mismatched++; $display("[TB] FAIL add_nibbles_b: got %h expected 0011", cap_b); end
      compared++; if (cap_op !== 1'b1) begin mismatched++; $display("[TB] FAIL add_op_pin: got %b expected 1", cap_op); end
      compared++; if (last_burst !== 5) begin mismatched++; $display("[TB] FAIL add_burst_len: got %0d expected 5", last_burst); end
      finish_rsp();
      compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL add_rsp_drop: got %b expected 0", rsp_valid); end
      compared++; if (req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL add_ready_back: got %b expected 1", req_ready); end
   endtask

   task automatic test_multiply();
      bit ok;
      int lat;
      op_high_seen = 0;
      send_req(16'h00FF, 16'h0002, 1'b0, ok);
      wait_rsp(lat, ok);
      compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL mul_rsp_timeout: got %b expected 1", ok); end
      compared++; if (lat !== 9) begin mismatched++; $display("[TB] FAIL mul_latency: got %0d expected 9", lat); end
      compared++; if (rsp_data !== 16'h01FE) begin mismatched++; $display("[TB] FAIL mul_data: got %h expected 01fe", rsp_data); end
      compared++; if (rsp_err !== 1'b0) begin mismatched++; $display("[TB] FAIL mul_err: got %b expected 0", rsp_err); end
      compared++; if (op_high_seen !== 1'b0) begin mismatched++; $display("[TB] FAIL mul_op_pin: got %b expected 0", op_high_seen); end
      finish_rsp();
   endtask

   task automatic test_timeout();
      bit ok;
      int lat;
      chip_enable = 0;
      send_req(16'h0005, 16'h0006, 1'b1, ok);
      wait_rsp(lat, ok);
      compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL to_rsp_timeout: got %b expected 1", ok); end
      compared++; if (lat !== 37) begin mismatched++; $display("[TB] FAIL to_latency: got %0d expected 37", lat); end
      compared++; if (rsp_err !== 1'b1) begin mismatched++; $display("[TB] FAIL to_err: got %b expected 1", rsp_err); end
      compared++; if (rsp_data !== 16'h0000) begin mismatched++; $display("[TB] FAIL to_data: got %h expected 0000", rsp_data); end
      finish_rsp();
      chip_enable = 1;
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      int b0;
      send_req(16'h0003, 16'h0004, 1'b0, ok);
      wait_rsp(lat, ok);
      compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_rsp_timeout: got %b expected 1", ok); end
      b0        = bursts;
      req_a     = 16'hAAAA;
      req_b     = 16'h5555;
      req_op    = 1'b1;
      req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_valid_hold: got %b expected 1", rsp_valid); end
         compared++; if (rsp_data !== 16'h000C) begin mismatched++; $display("[TB] FAIL bp_data_hold: got %h expected 000c", rsp_data); end
         compared++; if (req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_req_ready: got %b expected 0", req_ready); end
      end
      req_valid = 1'b0;
      compared++; if (bursts !== b0) begin mismatched++; $display("[TB] FAIL bp_no_accept: got %0d expected %0d", bursts, b0); end
      compared++; if (link_out[9] !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_no_strobe: got %b expected 0", link_out[9]); end
      finish_rsp();
   endtask

   task automatic test_reset_mid();
      bit ok;
      int lat;
      send_req(16'h1111, 16'h2222, 1'b1, ok);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      compared++; if (link_out !== 12'h000) begin mismatched++; $display("[TB] FAIL mid_link_out: got %h expected 000", link_out); end
      compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rsp_valid: got %b expected 0", rsp_valid); end
      compared++; if (req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_req_ready: got %b expected 0", req_ready); end
      reset = 1'b0;
      @(posedge clock); #1;
      compared++; if (req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_ready_after: got %b expected 1", req_ready); end
      compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_no_rsp: got %b expected 0", rsp_valid); end
      send_req(16'h0F0F, 16'h0101, 1'b1, ok);
      wait_rsp(lat, ok);
      compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_rsp_timeout: got %b expected 1", ok); end
      compared++; if (lat !== 9) begin mismatched++; $display("[TB] FAIL mid_latency: got %0d expected 9", lat); end
      compared++; if (rsp_data !== 16'h1010) begin mismatched++; $display("[TB] FAIL mid_data: got %h expected 1010", rsp_data); end
      finish_rsp();
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [3] = '{16'h0102, 16'h0010, 16'h8000};
      logic [15:0] vb [3] = '{16'h0304, 16'h0020, 16'h7FFF};
      logic        vo [3] = '{1'b1, 1'b0, 1'b1};
      logic [15:0] ve [3] = '{16'h0406, 16'h0200, 16'hFFFF};
      bit ok;
      int lat;
      int b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b0 = bursts;
         send_req(va[i], vb[i], vo[i], ok);
         wait_rsp(lat, ok);
         compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_rsp_timeout[%0d]: got %b expected 1", i, ok); end
         compared++; if (rsp_data !== ve[i]) begin mismatched++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, rsp_data, ve[i]); end
         compared++; if (last_burst !== 5) begin mismatched++; $display("[TB] FAIL b2b_burst_len[%0d]: got %0d expected 5", i, last_burst); end
         compared++; if (bursts !== b0 + 1) begin mismatched++; $display("[TB] FAIL b2b_burst_count[%0d]: got %0d expected %0d", i, bursts, b0 + 1); end
      end
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_end: got %b expected 0", rsp_valid); end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_op    = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      test_reset();
      test_add();
      test_multiply();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
